// File: rtl/mux4_rr_if.sv
// mux4_rr_if: lane and output handshake bundle for mux4_rr_sched.
//   in0..in3 / valid0..valid3 : lane data and lane valid (master -> slave)
//   ready0..ready3            : lane can accept a byte (slave -> master)
//   out / valid_out           : scheduled byte and its valid (slave -> master)
//   out_ready                 : downstream accepts out this cycle (master -> slave)
// Handshake: a lane byte transfers on a rising edge where valid_i & ready_i;
// the output byte transfers on a rising edge where valid_out & out_ready.
// ready_i never depends on valid_i, and valid_out never depends on out_ready.
interface mux4_rr_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             valid0, valid1, valid2, valid3;
  logic             ready0, ready1, ready2, ready3;
  logic [WIDTH-1:0] out;
  logic             valid_out;
  logic             out_ready;

  modport master (
    output in0, in1, in2, in3,
    output valid0, valid1, valid2, valid3,
    input  ready0, ready1, ready2, ready3,
    input  out, valid_out,
    output out_ready
  );

  modport slave (
    input  in0, in1, in2, in3,
    input  valid0, valid1, valid2, valid3,
    output ready0, ready1, ready2, ready3,
    output out, valid_out,
    input  out_ready
  );
endinterface

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: shares one WIDTH-bit output lane among four input lanes.
// Each lane owns a one-byte hold buffer; buffered bytes are granted either
// round-robin starting at ptr (idle lanes skipped) or strictly in lane order
// 0,1,2,3 (only lane ptr may be granted). The output byte is registered and
// held under downstream backpressure.
// Ports:
//   clkf      : clock, rising edge
//   reset     : asynchronous, active-high reset
//   en        : grant enable (0 blocks new grants; the output can still drain)
//   strict    : 0 = round-robin skipping idle lanes, 1 = strict lane order
//   bus       : lane and output handshakes (mux4_rr_if.slave)
//   lane_out  : source lane of the byte currently on out
//   ptr       : lane holding priority for the next grant
//   gnt_cnt   : total granted bytes, wraps silently
module mux4_rr_sched #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic            clkf,
  input  logic            reset,
  input  logic            en,
  input  logic            strict,
  mux4_rr_if.slave        bus,
  output logic [1:0]      lane_out,
  output logic [1:0]      ptr,
  output logic [CNTW-1:0] gnt_cnt
);

  logic [WIDTH-1:0] lane_in [4];
  logic [3:0]       lane_valid;
  logic [WIDTH-1:0] hbuf [4];
  logic [3:0]       hfull;
  logic [WIDTH-1:0] out_q;
  logic             valid_out_q;

  logic             load;
  logic             gnt_any;
  logic [1:0]       gnt;
  logic             do_grant;

  assign lane_in[0] = bus.in0;
  assign lane_in[1] = bus.in1;
  assign lane_in[2] = bus.in2;
  assign lane_in[3] = bus.in3;
  assign lane_valid = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};

  // Ready reflects only the hold-buffer state, so a full lane can never be
  // accepted and granted in the same cycle.
  assign bus.ready0 = ~hfull[0];
  assign bus.ready1 = ~hfull[1];
  assign bus.ready2 = ~hfull[2];
  assign bus.ready3 = ~hfull[3];

  assign bus.out       = out_q;
  assign bus.valid_out = valid_out_q;

  // The output register may take a new byte when it is empty or being drained.
  assign load = ~valid_out_q | bus.out_ready;

  // Grant selection. Round-robin scans from offset 3 down to 0 so the lowest
  // offset from ptr that is full is the one left in gnt.
  always_comb begin
    gnt     = ptr;
    gnt_any = 1'b0;
    if (strict) begin
      gnt_any = hfull[ptr];
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (hfull[ptr + 2'(k)]) begin
          gnt     = ptr + 2'(k);
          gnt_any = 1'b1;
        end
      end
    end
  end

  assign do_grant = load & en & gnt_any;

  // Hold buffers: a grant empties the lane, otherwise an empty lane accepts.
  always_ff @(posedge clkf or posedge reset) begin
    if (reset) begin
      hfull <= '0;
      for (int i = 0; i < 4; i++) hbuf[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (do_grant && (gnt == 2'(i))) begin
          hfull[i] <= 1'b0;
        end else if (lane_valid[i] && !hfull[i]) begin
          hfull[i] <= 1'b1;
          hbuf[i]  <= lane_in[i];
        end
      end
    end
  end

  // Output stage, priority pointer and grant counter. out and lane_out keep
  // their last value when nothing new is loaded; ptr moves only on a grant.
  always_ff @(posedge clkf or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      valid_out_q <= 1'b0;
      lane_out    <= 2'd0;
      ptr         <= 2'd0;
      gnt_cnt     <= '0;
    end else if (do_grant) begin
      out_q       <= hbuf[gnt];
      valid_out_q <= 1'b1;
      lane_out    <= gnt;
      ptr         <= gnt + 2'd1;
      gnt_cnt     <= gnt_cnt + CNTW'(1);
    end else if (load) begin
      valid_out_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
module tb_mux4_rr_sched;
  localparam int WIDTH = 8;
  localparam int CNTW  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic            clkf = 1'b0;
  logic            reset;
  logic            en;
  logic            strict;
  logic [1:0]      lane_out;
  logic [1:0]      ptr;
  logic [CNTW-1:0] gnt_cnt;

  mux4_rr_if #(.WIDTH(WIDTH)) bus ();

  mux4_rr_sched #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clkf     (clkf),
    .reset    (reset),
    .en       (en),
    .strict   (strict),
    .bus      (bus),
    .lane_out (lane_out),
    .ptr      (ptr),
    .gnt_cnt  (gnt_cnt)
  );

  always #5 clkf = ~clkf;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rdy();
    return {bus.ready3, bus.ready2, bus.ready1, bus.ready0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_valid(input logic [3:0] v);
    bus.valid0 = v[0];
    bus.valid1 = v[1];
    bus.valid2 = v[2];
    bus.valid3 = v[3];
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    bus.in0 = d0;
    bus.in1 = d1;
    bus.in2 = d2;
    bus.in3 = d3;
  endtask

  // One rising edge; returns at the following falling edge.
  task automatic tick();
    @(posedge clkf);
    @(negedge clkf);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Lane buffers as full flags plus byte; exp_q holds the byte that should be
  // sitting on the output ({lane, data}), empty when valid_out must be low.
  logic [WIDTH+1:0] exp_q[$];
  bit               m_full [4];
  logic [WIDTH-1:0] m_byte [4];
  logic [WIDTH-1:0] m_din  [4];
  bit               m_vin  [4];
  bit               m_empty[4];
  int               m_ptr = 0;
  int               m_g;
  bit               m_load;
  logic [CNTW-1:0]  m_cnt = '0;

  always @(posedge clkf or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      for (int l = 0; l < 4; l++) m_full[l] = 1'b0;
      m_ptr = 0;
      m_cnt = '0;
    end else begin
      m_din[0] = bus.in0;  m_din[1] = bus.in1;  m_din[2] = bus.in2;  m_din[3] = bus.in3;
      m_vin[0] = bus.valid0; m_vin[1] = bus.valid1; m_vin[2] = bus.valid2; m_vin[3] = bus.valid3;
      m_load = (exp_q.size() == 0) || bus.out_ready;
      if (m_load && exp_q.size() != 0) void'(exp_q.pop_front());
      m_g = -1;
      if (m_load && en) begin
        if (strict) begin
          if (m_full[m_ptr]) m_g = m_ptr;
        end else begin
          for (int off = 0; off < 4; off++)
            if (m_g < 0 && m_full[(m_ptr + off) % 4]) m_g = (m_ptr + off) % 4;
        end
      end
      for (int l = 0; l < 4; l++) m_empty[l] = !m_full[l];
      if (m_g >= 0) begin
        exp_q.push_back({2'(m_g), m_byte[m_g]});
        m_full[m_g] = 1'b0;
        m_ptr = (m_g + 1) % 4;
        m_cnt = m_cnt + 1'b1;
      end
      for (int l = 0; l < 4; l++) begin
        if (m_empty[l] && m_vin[l]) begin
          m_full[l] = 1'b1;
          m_byte[l] = m_din[l];
        end
      end
    end
  end

  always @(negedge clkf) begin
    if (chk_en && !reset) begin
      check("model_valid_out", 32'(bus.valid_out), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("model_lane_out", 32'({lane_out, bus.out}), 32'(exp_q[0]));
      check("model_ptr", 32'(ptr), 32'(m_ptr));
      check("model_gnt_cnt", 32'(gnt_cnt), 32'(m_cnt));
      check("model_ready", 32'(rdy()),
            32'({!m_full[3], !m_full[2], !m_full[1], !m_full[0]}));
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0] valid;
    logic       oready;
    logic       vout;
    logic [7:0] out;
    logic [1:0] lane;
    logic [1:0] ptr;
    logic [15:0] cnt;
    logic [3:0] rdy;
  } vec_t;

  vec_t tbl [15];
  int   budget;

  // ---------------- test ----------------
  initial begin
    // Round-robin fill, steady state, then five cycles of backpressure.
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 8'h00, 2'd0, 2'd0, 16'd0, 4'b0000};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 8'hA0, 2'd0, 2'd1, 16'd1, 4'b0001};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 8'hB1, 2'd1, 2'd2, 16'd2, 4'b0010};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 8'hC2, 2'd2, 2'd3, 16'd3, 4'b0100};
    tbl[4]  = '{4'hF, 1'b1, 1'b1, 8'hD3, 2'd3, 2'd0, 16'd4, 4'b1000};
    tbl[5]  = '{4'hF, 1'b1, 1'b1, 8'hA0, 2'd0, 2'd1, 16'd5, 4'b0001};
    tbl[6]  = '{4'hF, 1'b1, 1'b1, 8'hB1, 2'd1, 2'd2, 16'd6, 4'b0010};
    tbl[7]  = '{4'hF, 1'b1, 1'b1, 8'hC2, 2'd2, 2'd3, 16'd7, 4'b0100};
    tbl[8]  = '{4'hF, 1'b1, 1'b1, 8'hD3, 2'd3, 2'd0, 16'd8, 4'b1000};
    for (int i = 9; i < 14; i++)
      tbl[i] = '{4'hF, 1'b0, 1'b1, 8'hD3, 2'd3, 2'd0, 16'd8, 4'b0000};
    tbl[14] = '{4'hF, 1'b1, 1'b1, 8'hA0, 2'd0, 2'd1, 16'd9, 4'b0001};

    reset = 1'b1;
    en = 1'b1;
    strict = 1'b0;
    bus.out_ready = 1'b1;
    set_valid(4'h0);
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_valid_out", 32'(bus.valid_out), 32'h0);
    check("rst_lane_out", 32'(lane_out), 32'h0);
    check("rst_ptr", 32'(ptr), 32'h0);
    check("rst_gnt_cnt", 32'(gnt_cnt), 32'h0);
    check("rst_ready", 32'(rdy()), 32'hF);
    @(negedge clkf);
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Table-driven round-robin and backpressure.
    set_data(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    for (int i = 0; i < 15; i++) begin
      set_valid(tbl[i].valid);
      bus.out_ready = tbl[i].oready;
      tick();
      check($sformatf("tbl%0d_valid_out", i), 32'(bus.valid_out), 32'(tbl[i].vout));
      check($sformatf("tbl%0d_out", i), 32'(bus.out), 32'(tbl[i].out));
      check($sformatf("tbl%0d_lane_out", i), 32'(lane_out), 32'(tbl[i].lane));
      check($sformatf("tbl%0d_ptr", i), 32'(ptr), 32'(tbl[i].ptr));
      check($sformatf("tbl%0d_gnt_cnt", i), 32'(gnt_cnt), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_ready", i), 32'(rdy()), 32'(tbl[i].rdy));
    end

    // All lanes full, then reset asserted between edges.
    bus.out_ready = 1'b0;
    tick();
    check("prerst_all_full", 32'(rdy()), 32'h0);
    check("prerst_valid_out", 32'(bus.valid_out), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out", 32'(bus.out), 32'h0);
    check("arst_valid_out", 32'(bus.valid_out), 32'h0);
    check("arst_lane_out", 32'(lane_out), 32'h0);
    check("arst_ptr", 32'(ptr), 32'h0);
    check("arst_gnt_cnt", 32'(gnt_cnt), 32'h0);
    check("arst_ready", 32'(rdy()), 32'hF);
    set_valid(4'h0);
    bus.out_ready = 1'b1;
    @(negedge clkf);
    tick();
    reset = 1'b0;
    tick();
    check("postrst_no_emit", 32'(bus.valid_out), 32'h0);
    check("postrst_ready", 32'(rdy()), 32'hF);

    // Skip idle lanes: only lanes 1 and 3 active.
    set_data(8'h00, 8'h11, 8'h00, 8'h33);
    set_valid(4'b1010);
    tick();
    check("skip_fill_valid_out", 32'(bus.valid_out), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("skip%0d_out", k), 32'(bus.out), (k % 2) ? 32'h33 : 32'h11);
      check($sformatf("skip%0d_lane", k), 32'(lane_out), (k % 2) ? 32'd3 : 32'd1);
      check($sformatf("skip%0d_ptr", k), 32'(ptr), (k % 2) ? 32'd0 : 32'd2);
    end
    set_valid(4'h0);
    tick();
    tick();
    check("skip_drain_idle", 32'(bus.valid_out), 32'h0);

    // Strict order: lane 2 waits for lane 0.
    do_reset();
    strict = 1'b1;
    set_data(8'h00, 8'h00, 8'h22, 8'h00);
    set_valid(4'b0100);
    tick();
    set_valid(4'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("strict_wait%0d_valid_out", k), 32'(bus.valid_out), 32'h0);
      check($sformatf("strict_wait%0d_ptr", k), 32'(ptr), 32'h0);
    end
    set_data(8'h00, 8'h00, 8'h22, 8'h00);
    set_valid(4'b0001);
    tick();
    check("strict_accept_edge", 32'(bus.valid_out), 32'h0);
    set_valid(4'h0);
    tick();
    check("strict_out", 32'(bus.out), 32'h00);
    check("strict_valid_out", 32'(bus.valid_out), 32'h1);
    check("strict_lane", 32'(lane_out), 32'h0);
    check("strict_ptr", 32'(ptr), 32'h1);

    // Enable low: output drains, lane 2 stays buffered.
    en = 1'b0;
    strict = 1'b0;
    tick();
    check("en0_valid_out", 32'(bus.valid_out), 32'h0);
    check("en0_lane2_kept", 32'(bus.ready2), 32'h0);
    check("en0_ptr_hold", 32'(ptr), 32'h1);
    check("en0_out_hold", 32'(bus.out), 32'h00);
    en = 1'b1;
    tick();
    check("en1_out", 32'(bus.out), 32'h22);
    check("en1_lane", 32'(lane_out), 32'h2);
    check("en1_ptr", 32'(ptr), 32'h3);
    check("en1_gnt_cnt", 32'(gnt_cnt), 32'h2);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      set_valid(4'($urandom_range(0, 15)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) strict = ~strict;
      tick();
    end

    // Full load until the grant counter wraps.
    strict = 1'b0;
    en = 1'b1;
    bus.out_ready = 1'b1;
    set_valid(4'hF);
    budget = 0;
    while (m_cnt != 16'hFFFF && budget < 70000) begin
      set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      budget++;
    end
    check("wrap_budget", 32'(budget < 70000), 32'h1);
    check("wrap_pre", 32'(gnt_cnt), 32'hFFFF);
    tick();
    check("wrap_post", 32'(gnt_cnt), 32'h0);
    check("wrap_valid_out", 32'(bus.valid_out), 32'h1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler sharing one 8-bit output lane among four 8-bit input lanes, each with a valid/ready handshake.
- Sits between the 4-lane flop stage and the 4:1 byte mux path of the physical layer.
- Buffers one byte per lane and grants lanes either round-robin (skipping idle lanes) or in strict lane order 0,1,2,3 for byte striping.
- A registered output stage supports downstream backpressure.

Parameters:
- WIDTH, 8, data width of every input lane and of the output.
- CNTW, 16, width of the granted-byte counter.

Ports:
- clkf  input  1  single clock, all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  grant enable; 0 blocks new grants, output may still drain
- strict  input  1  0 = round-robin skipping idle lanes, 1 = strict lane order
- in0..in3  input  WIDTH each  lane data
- valid0..valid3  input  1 each  lane data valid
- ready0..ready3  output  1 each  lane can accept (= hold buffer empty)
- out  output  WIDTH  scheduled byte (registered)
- valid_out  output  1  out holds a byte (registered)
- out_ready  input  1  downstream accepts out this cycle
- lane_out  output  2  source lane of current out
- ptr  output  2  next lane with priority
- gnt_cnt  output  CNTW  total bytes granted, wraps modulo 2^CNTW

Behaviour:
- Reset (asynchronous assert, effective immediately):
  - out, valid_out, lane_out, ptr and gnt_cnt = 0.
  - All hold buffers are empty, so ready0..3 = 1.
  - Reset mid-operation discards all buffered and output bytes without emitting them.
- Per lane i:
  - hfull_i flag plus hbuf_i register.
  - ready_i = ~hfull_i, combinational from state only, never from valid_i.
  - Accept when valid_i & ready_i: hbuf_i <= in_i and hfull_i <= 1 at the next edge.
  - ready_i is 0 while full, so a lane sustains at most 1 byte per 2 cycles. Aggregate throughput across lanes is 1 byte/cycle.
- Output load condition: load = ~valid_out | out_ready.
- Eligible lanes:
  - strict = 0: every lane with hfull set. The grant is the first eligible lane scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - strict = 1: only lane ptr. Other full lanes wait, even if ptr's lane is empty.
- Grant happens when load & en & an eligible lane exists. At the next edge:
  - out <= hbuf_g, lane_out <= g, valid_out <= 1.
  - hfull_g <= 0.
  - ptr <= g+1 (mod 4, 3 wraps to 0).
  - gnt_cnt <= gnt_cnt+1.
- No grant but load true (idle, en = 0, or the strict lane is empty): valid_out <= 0, while out and lane_out hold their values.
- load false (valid_out & ~out_ready): out, valid_out, lane_out, ptr and hold buffers stay unchanged, apart from new lane accepts.
- Latency: a byte accepted at edge N is visible on out no earlier than edge N+1.
- A lane cannot be accepted and granted in the same cycle, because ready is 0 while full.
- ptr advances only on a grant, never on idle cycles.
- Changing strict or en takes effect at the next arbitration evaluation, with no flush. Buffered bytes are preserved.
- gnt_cnt wraps from 2^CNTW-1 to 0 without a flag.

Test Plan:
- Reset: assert reset mid-cycle with all lanes full -> outputs go to 0 immediately without waiting for an edge, ready0..3 = 1, ptr = 0, gnt_cnt = 0.
- Round-robin full load: all valids held high with in0=8'hA0, in1=8'hB1, in2=8'hC2, in3=8'hD3, out_ready = 1, strict = 0 -> out repeats A0,B1,C2,D3 with lane_out 0,1,2,3 and valid_out continuous after fill. After 8 grants gnt_cnt = 8.
- Skip idle: only lanes 1 and 3 valid (8'h11, 8'h33) -> out alternates 11,33, ptr alternates 2,0.
- Strict order: strict = 1, lane 2 full (8'h22), lanes 0 and 1 empty, ptr = 0 -> no grant and valid_out = 0 until lane 0 gets 8'h00. Then out = 00, ptr = 1.
- Backpressure: out_ready = 0 for 5 cycles with all lanes full -> out and lane_out stable and ready0..3 = 0. On release, grants resume at the lane after lane_out.
- Enable/wrap: en = 0 with valid_out = 1 and out_ready = 1 -> valid_out drops next cycle and no hbuf is consumed. Preload gnt_cnt to 16'hFFFF, then one grant -> gnt_cnt = 0.
